// File: rtl/area_batch_stats_if.sv
// Stream of area samples into the batch statistics block and batch results out.
interface area_batch_stats_if #(
  parameter int unsigned SUM_W = 25
);
  logic [16:0]      area;
  logic             area_valid;
  logic             in_ready;
  logic             clear;
  logic             stats_valid;
  logic             stats_ready;
  logic [SUM_W-1:0] sum;
  logic [16:0]      max_area;
  logic [16:0]      min_area;
  logic [16:0]      mean;

  modport master (
    output area, area_valid, clear, stats_ready,
    input  in_ready, stats_valid, sum, max_area, min_area, mean
  );

  modport slave (
    input  area, area_valid, clear, stats_ready,
    output in_ready, stats_valid, sum, max_area, min_area, mean
  );
endinterface

// File: rtl/area_batch_stats.sv
// Batches area samples and reports sum/max/min per batch of BATCH_LEN.
// Optional truncated mean via a serial divider when AREA_BATCH_MEAN_EN is defined.
module area_batch_stats #(
  parameter int unsigned BATCH_LEN = 8,
  parameter int unsigned SUM_W     = 25
) (
  input logic               CLK,
  input logic               RST,
  area_batch_stats_if.slave bus
);

  localparam int unsigned CNT_W = $clog2(BATCH_LEN + 1);

`ifdef AREA_BATCH_MEAN_EN
  typedef enum logic [1:0] {IDLE, ACCUM, DIVIDE, HOLD} state_t;
  localparam state_t LAST_STATE = DIVIDE;
`else
  typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_t;
  localparam state_t LAST_STATE = HOLD;
`endif

  state_t           state_q, state_d;
  logic [CNT_W-1:0] count_q;
  logic [SUM_W-1:0] sum_q;
  logic [SUM_W-1:0] sum_next;
  logic [16:0]      max_q;
  logic [16:0]      min_q;
  logic             in_ready;
  logic             stats_valid;
  logic             accept;
  logic             last;
  logic             restart;
  logic             div_done;

  assign in_ready    = (state_q == IDLE) || (state_q == ACCUM);
  assign stats_valid = (state_q == HOLD);

  // clear wins over both an incoming sample and the result handshake
  assign accept   = in_ready && bus.area_valid && !bus.clear;
  assign last     = (count_q == CNT_W'(BATCH_LEN - 1));
  assign restart  = bus.clear || (stats_valid && bus.stats_ready);
  assign sum_next = sum_q + SUM_W'(bus.area);

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (bus.clear) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE, ACCUM: begin
          if (accept) state_d = last ? LAST_STATE : ACCUM;
        end
`ifdef AREA_BATCH_MEAN_EN
        DIVIDE: begin
          if (div_done) state_d = HOLD;
        end
`endif
        HOLD: begin
          if (bus.stats_ready) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      count_q <= '0;
      sum_q   <= '0;
      max_q   <= '0;
      min_q   <= '1;
    end else if (restart) begin
      count_q <= '0;
      sum_q   <= '0;
      max_q   <= '0;
      min_q   <= '1;
    end else if (accept) begin
      count_q <= count_q + 1'b1;
      sum_q   <= sum_next;
      if (bus.area > max_q) max_q <= bus.area;
      if (bus.area < min_q) min_q <= bus.area;
    end
  end

`ifdef AREA_BATCH_MEAN_EN
  localparam int unsigned STEP_W = $clog2(SUM_W);
  localparam int unsigned REM_W  = $clog2(BATCH_LEN + 1);
  localparam logic [REM_W:0] DIVISOR = (REM_W + 1)'(BATCH_LEN);

  logic [SUM_W-1:0]  quo_q, quo_next;
  logic [REM_W-1:0]  rem_q, rem_next;
  logic [REM_W:0]    partial;
  logic [STEP_W-1:0] step_q;
  logic [16:0]       mean_q;

  assign div_done = (step_q == STEP_W'(SUM_W - 1));

  // Restoring division: the dividend shifts out of quo_q MSB-first while
  // quotient bits shift in at the bottom; the remainder never reaches BATCH_LEN.
  always_comb begin
    partial = {rem_q, quo_q[SUM_W-1]};
    if (partial >= DIVISOR) begin
      rem_next = REM_W'(partial - DIVISOR);
      quo_next = {quo_q[SUM_W-2:0], 1'b1};
    end else begin
      rem_next = REM_W'(partial);
      quo_next = {quo_q[SUM_W-2:0], 1'b0};
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      quo_q  <= '0;
      rem_q  <= '0;
      step_q <= '0;
      mean_q <= '0;
    end else if (accept && last) begin
      quo_q  <= sum_next;
      rem_q  <= '0;
      step_q <= '0;
    end else if ((state_q == DIVIDE) && !bus.clear) begin
      quo_q  <= quo_next;
      rem_q  <= rem_next;
      step_q <= step_q + 1'b1;
      if (div_done) mean_q <= quo_next[16:0];
    end
  end

  assign bus.mean = mean_q;
`else
  assign div_done = 1'b0;
  assign bus.mean = '0;
`endif

  assign bus.in_ready    = in_ready;
  assign bus.stats_valid = stats_valid;
  assign bus.sum         = sum_q;
  assign bus.max_area    = max_q;
  assign bus.min_area    = min_q;

endmodule

// File: tb/tb_area_batch_stats.sv
// Directed bench for area_batch_stats: vector table of full batches plus
// stall, clear, reset and (with AREA_BATCH_MEAN_EN) divider-abort sequences.
module tb_area_batch_stats;
  localparam int unsigned BATCH_LEN = 8;
  localparam int unsigned SUM_W     = 25;
`ifdef AREA_BATCH_MEAN_EN
  localparam bit MEAN_EN = 1'b1;
`else
  localparam bit MEAN_EN = 1'b0;
`endif
  localparam int unsigned LAT = MEAN_EN ? SUM_W : 0;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  area_batch_stats_if #(.SUM_W(SUM_W)) bus ();

  area_batch_stats #(.BATCH_LEN(BATCH_LEN), .SUM_W(SUM_W)) dut (
    .CLK(clk),
    .RST(rst),
    .bus(bus)
  );

  typedef struct packed {
    logic [7:0][16:0] s;
    logic [3:0]       gap;
    logic [31:0]      sum;
    logic [31:0]      max;
    logic [31:0]      min;
    logic [31:0]      mean;
  } vec_t;

  vec_t vecs[5];
  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [16:0] v, input int unsigned gap);
    bus.area       = v;
    bus.area_valid = 1'b1;
    tick();
    bus.area_valid = 1'b0;
    repeat (gap) tick();
  endtask

  task automatic wait_valid(output int unsigned cyc);
    cyc = 0;
    while (!bus.stats_valid && cyc < 200) begin
      tick();
      cyc++;
    end
  endtask

  function automatic logic [31:0] exp_mean(input logic [31:0] m);
    return MEAN_EN ? m : 32'd0;
  endfunction

  initial begin
    int unsigned cyc;

    vecs[0].s = {8{17'd457}};
    vecs[0].gap = 0; vecs[0].sum = 3656; vecs[0].max = 457; vecs[0].min = 457; vecs[0].mean = 457;
    vecs[1].s = {17'd457, 17'd457, 17'd457, 17'd457, 17'd457, 17'd457, 17'd116079, 17'd0};
    vecs[1].gap = 2; vecs[1].sum = 118821; vecs[1].max = 116079; vecs[1].min = 0; vecs[1].mean = 14852;
    vecs[2].s = {17'd6, 17'd8, 17'd2, 17'd7, 17'd1, 17'd9, 17'd3, 17'd5};
    vecs[2].gap = 1; vecs[2].sum = 41; vecs[2].max = 9; vecs[2].min = 1; vecs[2].mean = 5;
    vecs[3].s = {8{17'h1FFFF}};
    vecs[3].gap = 0; vecs[3].sum = 1048568; vecs[3].max = 131071; vecs[3].min = 131071; vecs[3].mean = 131071;
    vecs[4].s = '0;
    vecs[4].gap = 3; vecs[4].sum = 0; vecs[4].max = 0; vecs[4].min = 0; vecs[4].mean = 0;

    rst = 1'b0;
    bus.area = '0;
    bus.area_valid = 1'b0;
    bus.clear = 1'b0;
    bus.stats_ready = 1'b1;
    repeat (2) tick();
    check("rst_stats_valid", bus.stats_valid, 0);
    check("rst_sum", bus.sum, 0);
    check("rst_max", bus.max_area, 0);
    check("rst_min", bus.min_area, 32'h1FFFF);
    check("rst_mean", bus.mean, 0);
    @(negedge clk) rst = 1'b1;
    tick();
    check("rel_in_ready", bus.in_ready, 1);
    check("rel_stats_valid", bus.stats_valid, 0);
    check("rel_min", bus.min_area, 32'h1FFFF);

    // asynchronous reset asserted mid-cycle with a partial batch present
    send(17'd1234, 0);
    send(17'd50, 0);
    check("pre_async_sum", bus.sum, 1284);
    #2 rst = 1'b0;
    #1;
    check("async_sum", bus.sum, 0);
    check("async_max", bus.max_area, 0);
    check("async_min", bus.min_area, 32'h1FFFF);
    check("async_in_ready", bus.in_ready, 1);
    @(negedge clk) rst = 1'b1;
    tick();

    for (int k = 0; k < 5; k++) begin
      for (int i = 0; i < 8; i++) send(vecs[k].s[i], (i == 7) ? 0 : int'(vecs[k].gap));
      wait_valid(cyc);
      check($sformatf("v%0d_latency", k), cyc, LAT);
      check($sformatf("v%0d_valid", k), bus.stats_valid, 1);
      check($sformatf("v%0d_sum", k), bus.sum, vecs[k].sum);
      check($sformatf("v%0d_max", k), bus.max_area, vecs[k].max);
      check($sformatf("v%0d_min", k), bus.min_area, vecs[k].min);
      check($sformatf("v%0d_mean", k), bus.mean, exp_mean(vecs[k].mean));
      check($sformatf("v%0d_in_ready_hold", k), bus.in_ready, 0);
      tick();
      check($sformatf("v%0d_valid_drop", k), bus.stats_valid, 0);
      check($sformatf("v%0d_sum_zero", k), bus.sum, 0);
      check($sformatf("v%0d_min_reset", k), bus.min_area, 32'h1FFFF);
      check($sformatf("v%0d_mean_kept", k), bus.mean, exp_mean(vecs[k].mean));
      check($sformatf("v%0d_in_ready_idle", k), bus.in_ready, 1);
    end

    // consumer stalls while the producer keeps offering a sample
    bus.stats_ready = 1'b0;
    for (int i = 0; i < 8; i++) send(17'd50, 0);
    wait_valid(cyc);
    check("stall_valid", bus.stats_valid, 1);
    bus.area = 17'd999;
    bus.area_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      check($sformatf("stall%0d_valid", i), bus.stats_valid, 1);
      check($sformatf("stall%0d_in_ready", i), bus.in_ready, 0);
      check($sformatf("stall%0d_sum", i), bus.sum, 400);
    end
    bus.stats_ready = 1'b1;
    tick();
    check("stall_hs_sum", bus.sum, 0);
    check("stall_hs_in_ready", bus.in_ready, 1);
    tick();
    bus.area_valid = 1'b0;
    check("stall_first_sum", bus.sum, 999);
    check("stall_first_min", bus.min_area, 999);
    for (int i = 0; i < 7; i++) send(17'd1, 0);
    wait_valid(cyc);
    check("stall_batch_sum", bus.sum, 1006);
    check("stall_batch_max", bus.max_area, 999);
    check("stall_batch_min", bus.min_area, 1);
    check("stall_batch_mean", bus.mean, exp_mean(125));
    tick();

    // clear together with a valid sample drops it and restarts the batch
    send(17'd100, 0);
    send(17'd200, 0);
    send(17'd300, 0);
    check("clr_pre_sum", bus.sum, 600);
    bus.area = 17'd400;
    bus.area_valid = 1'b1;
    bus.clear = 1'b1;
    tick();
    bus.clear = 1'b0;
    bus.area_valid = 1'b0;
    check("clr_sum", bus.sum, 0);
    check("clr_max", bus.max_area, 0);
    check("clr_min", bus.min_area, 32'h1FFFF);
    check("clr_in_ready", bus.in_ready, 1);
    for (int i = 0; i < 8; i++) send(17'd10, 0);
    wait_valid(cyc);
    check("clr_batch_valid", bus.stats_valid, 1);
    check("clr_batch_sum", bus.sum, 80);
    check("clr_batch_mean", bus.mean, exp_mean(10));
    tick();

    // clear while results are held
    bus.stats_ready = 1'b0;
    for (int i = 0; i < 8; i++) send(17'd3, 0);
    wait_valid(cyc);
    bus.clear = 1'b1;
    tick();
    bus.clear = 1'b0;
    check("clr_hold_valid", bus.stats_valid, 0);
    check("clr_hold_sum", bus.sum, 0);
    check("clr_hold_mean", bus.mean, exp_mean(3));
    bus.stats_ready = 1'b1;

`ifdef AREA_BATCH_MEAN_EN
    // reset during the tenth divide cycle aborts the division
    for (int i = 0; i < 8; i++) send(17'd457, 0);
    repeat (9) tick();
    check("div_in_ready", bus.in_ready, 0);
    #2 rst = 1'b0;
    #1;
    check("div_rst_mean", bus.mean, 0);
    check("div_rst_valid", bus.stats_valid, 0);
    check("div_rst_sum", bus.sum, 0);
    @(negedge clk) rst = 1'b1;
    tick();
    for (int i = 0; i < 8; i++) send(17'd20, 0);
    wait_valid(cyc);
    check("div_after_latency", cyc, SUM_W);
    check("div_after_sum", bus.sum, 160);
    check("div_after_mean", bus.mean, 20);
    tick();
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/area_batch_stats.md
Name: area_batch_stats

Overview:
Downstream consumer of the area-calculation stage. Collects a stream of 17-bit area results with valid/ready handshaking and groups them into batches of BATCH_LEN samples. For each batch it reports the sum, maximum and minimum, and optionally the truncated mean. Results are held on the output with a valid/ready handshake until the consumer takes them.

Parameters:
BATCH_LEN, 8, samples per batch; legal range 1..256.
SUM_W, 25, sum width; must be >= 17 + ceil(log2(BATCH_LEN)), so the sum never overflows.

Ports:
CLK  input  1  clock, rising edge
RST  input  1  reset, asynchronous, active-low
area  input  17  area sample, unsigned
area_valid  input  1  area holds a sample this cycle
in_ready  output  1  block can accept a sample this cycle
clear  input  1  synchronous batch abort
stats_valid  output  1  batch results are valid
stats_ready  input  1  consumer takes the results
sum  output  SUM_W  sum of the batch samples
max_area  output  17  largest sample in the batch
min_area  output  17  smallest sample in the batch
mean  output  17  sum / BATCH_LEN, truncated (0 when the feature is absent)

Behaviour:
- Reset (RST low, asynchronous) values: state IDLE, count 0, sum 0, max_area 0, min_area 17'h1FFFF, mean 0, stats_valid 0. in_ready is 1 after reset releases.
- States: IDLE, ACCUM, DIVIDE (feature only), HOLD.
- in_ready = 1 in IDLE and ACCUM; 0 in DIVIDE and HOLD. It is decoded combinationally from state and is registered-state-only.
- Accept = area_valid && in_ready, evaluated on the rising edge.
- On each accept:
  - sum <= sum + area, zero-extended to SUM_W.
  - max_area <= max(max_area, area).
  - min_area <= min(min_area, area).
  - count++.
- IDLE -> ACCUM on the first accept.
- ACCUM stays in ACCUM until the accept that makes count == BATCH_LEN. On that edge it goes to HOLD, or to DIVIDE when the feature is built.
- BATCH_LEN = 1: the first accept in IDLE goes directly to HOLD/DIVIDE.
- Cycles without area_valid: no change in any state. Gaps between samples are allowed.
- HOLD: stats_valid = 1. sum, max_area, min_area and mean are stable until stats_valid && stats_ready.
- On the HOLD handshake edge:
  - Go to IDLE; count 0.
  - sum 0, max_area 0, min_area 17'h1FFFF.
  - mean keeps its last value.
  - stats_valid drops on the same edge.
- Latency (no feature): stats_valid rises on the edge that accepts the last sample, so it is visible in the next cycle.
- area_valid during HOLD is not accepted: in_ready is 0 and the producer must stall. A sample arriving on the HOLD handshake cycle is also not accepted; it is accepted at the earliest in the following cycle (IDLE).
- clear = 1, in any state: on the next edge go to IDLE with the same zeroing as the HOLD handshake, and stats_valid = 0.
  - clear has priority over accept and over the handshake.
  - A sample presented while clear = 1 is discarded.
- The sum cannot wrap under the SUM_W rule. No saturation logic is present.

Optional Feature:
AREA_BATCH_MEAN_EN
- Defined:
  - The transition out of ACCUM goes to DIVIDE.
  - An unsigned restoring divider, one quotient bit per cycle, computes sum / BATCH_LEN over exactly SUM_W cycles.
  - mean is loaded with the quotient's low 17 bits, then the state goes to HOLD.
  - stats_valid rises SUM_W cycles after the last accept edge.
  - in_ready = 0 throughout DIVIDE.
  - clear or RST in DIVIDE aborts the division; mean then stays at its previous value (0 after reset).
- Undefined: no DIVIDE state or divider logic; mean is tied to 0.

Test Plan:
1. Assert RST low mid-cycle -> all outputs take reset values immediately; after release in_ready = 1, stats_valid = 0, min_area = 17'h1FFFF.
2. 8 back-to-back samples of 457, stats_ready = 1 ->
   - sum = 3656, max_area = min_area = 457.
   - stats_valid high for 1 cycle.
   - mean = 457 when the feature is built; stats_valid rises 25 cycles after the last sample edge.
3. Samples 0, 116079, then 6 x 457, with 2-cycle gaps between samples ->
   - sum = 118821, max_area = 116079, min_area = 0.
   - mean = 14852 when the feature is built.
4. Hold stats_ready = 0 for 6 cycles after stats_valid, with area_valid = 1 throughout ->
   - outputs stay stable and in_ready = 0; no sample is counted.
   - After stats_ready = 1, the next batch starts with the first sample that is accepted.
5. Accept 3 samples (100, 200, 300), then pulse clear together with area_valid ->
   - state IDLE, sum 0, and that sample is dropped.
   - The next 8 samples of 10 give sum = 80.
6. With the feature built, drive RST low in the 10th DIVIDE cycle -> reset values and mean = 0; the next full batch completes normally.
